alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
Parametrised successor to the execute-stage integer ALU. Adds RV32M/RV64M multiply/divide and registered output with valid/ready handshakes on input and output. Base ops complete in 1 cycle; MUL*/DIV*/REM* run iteratively, one bit per cycle, with early-out cases. Sits in EX stage; the pipeline stalls on in_ready/out_valid and kills in-flight work via flush.

Parameters:
XLEN, 32, operand/result width; power of two, 8..64
SHW, $clog2(XLEN), shift-amount width (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of accepted/in-flight op
in_valid  input  1  operands/op valid
in_ready  output  1  block can accept (state IDLE)
op  input  5  operation code (below)
src1  input  XLEN  operand 1 (rs1 / dividend / multiplicand)
src2  input  XLEN  operand 2 (rs2 / divisor / multiplier / shamt)
out_valid  output  1  result valid
out_ready  input  1  consumer takes result
result  output  XLEN  result, stable while out_valid && !out_ready
busy  output  1  state is MUL or DIV

Behaviour:
- Op codes: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SUB, 9 SRA; 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU; any other code -> result 0, base-op timing.
- Shifts use src2[SHW-1:0] only; SRA is arithmetic. SLT signed, SLTU unsigned compare; result 1 or 0 zero-extended. ADD/SUB wrap modulo 2^XLEN.
- Reset (rst_n low, async): state IDLE, out_valid 0, result 0, busy 0, counter 0, internal operand/accumulator regs 0. in_ready 1 after reset release.
- States: IDLE, MUL, DIV, DONE.
- Accept = in_valid && in_ready && !flush; in_ready = (state==IDLE).
- IDLE: accept base op -> result computed, registered, -> DONE (out_valid at T+1). Accept MUL* -> MUL, counter=0. Accept DIV* -> DIV, counter=0, unless early-out.
- MUL: shift-add on magnitudes, 2*XLEN-bit product, one multiplier bit per cycle; after XLEN cycles sign-correct (negate if signs differ for signed operands; MULHSU treats src2 unsigned), select low half (MUL) or high half (MULH*) -> DONE. out_valid at T+XLEN+1.
- DIV: restoring division on magnitudes, one quotient bit per cycle, XLEN cycles; quotient sign = sign1 XOR sign2 (signed ops); remainder takes dividend sign -> DONE at T+XLEN+1.
- Early-out (-> DONE, out_valid at T+1): divisor 0: DIV/DIVU result all-ones, REM/REMU result src1. Signed overflow (src1 = -2^(XLEN-1), src2 = -1): DIV result src1, REM result 0.
- DONE: out_valid=1, result held; out_valid && out_ready -> IDLE, out_valid 0 next cycle. No new accept while in DONE (1 bubble min between results).
- flush: in any state, next cycle state IDLE, out_valid 0, busy 0; result reg may hold stale data. flush with in_valid same cycle: no accept.
- out_ready ignored outside DONE. op/src change after accept has no effect (latched on accept).
- rst_n assertion mid-operation: immediate return to reset values, no result emitted.

Test Plan:
- XLEN=32: op ADD, src1 0x7FFFFFFF, src2 1, out_ready 1 -> out_valid at T+1, result 0x80000000; SRA 0x80000000 by src2 0x21 -> 0xC0000000 (shamt 1).
- MULH src1 0xFFFFFFFF (-1), src2 2 -> out_valid at T+33, result 0xFFFFFFFF; MULHU same operands -> 0x00000001; MUL -> 0xFFFFFFFE; busy high cycles T+1..T+32.
- DIV src1 -7, src2 2 -> 0xFFFFFFFD (-3) at T+33; REM -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14, REMU -> 2.
- DIV by 0 src1 0x1234 -> 0xFFFFFFFF at T+1; REM -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1, REM -> 0.
- Backpressure: MUL 3*5 with out_ready 0 for 10 cycles after out_valid -> result 15 held stable, in_ready 0 throughout; out_ready 1 -> out_valid 0, in_ready 1 next cycle.
- flush at T+10 of DIVU -> IDLE, out_valid never asserted; rst_n pulse low at T+5 of MUL -> all outputs reset values asynchronously, in_ready 1 after release.

Source files
------------

// File: rtl/alu_muldiv.sv
// Execute-stage integer ALU with iterative RV32M/RV64M multiply/divide.
// Base ops finish in one cycle; MUL*/DIV*/REM* retire one bit per cycle.
module alu_muldiv #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSll  = 5'd1;
  localparam logic [4:0] OpSlt  = 5'd2;
  localparam logic [4:0] OpSltu = 5'd3;
  localparam logic [4:0] OpXor  = 5'd4;
  localparam logic [4:0] OpSrl  = 5'd5;
  localparam logic [4:0] OpOr   = 5'd6;
  localparam logic [4:0] OpAnd  = 5'd7;
  localparam logic [4:0] OpSub  = 5'd8;
  localparam logic [4:0] OpSra  = 5'd9;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e              state_q, state_d;
  logic [SHW-1:0]      cnt_q, cnt_d;
  logic [1:0]          sel_q, sel_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept, is_mul, is_div, sgn1, sgn2, neg1, neg2;
  logic                div_zero, div_ovf, last;
  logic [XLEN-1:0]     mag1, mag2, base_res;
  logic [SHW-1:0]      shamt;
  logic [2*XLEN-1:0]   mul_sum, mul_prod;
  logic [XLEN:0]       rem_sh, rem_diff, rem_nx;
  logic                q_bit;
  logic [XLEN-1:0]     quo_nx, quo_fin, rem_fin;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StMul) || (state_q == StDiv);
  assign result    = result_q;

  assign accept = in_valid && in_ready && !flush;
  assign shamt  = src2[SHW-1:0];
  assign is_mul = (op[4:2] == 3'b100);
  assign is_div = (op[4:2] == 3'b101);
  // MULHSU keeps src1 signed; MULHU and the unsigned div ops treat both as unsigned.
  assign sgn1   = is_mul ? (op[1:0] != 2'b11) : !op[0];
  assign sgn2   = is_mul ? !op[1] : !op[0];
  assign neg1   = sgn1 && src1[XLEN-1];
  assign neg2   = sgn2 && src2[XLEN-1];
  assign mag1   = neg1 ? -src1 : src1;
  assign mag2   = neg2 ? -src2 : src2;

  assign div_zero = (src2 == '0);
  assign div_ovf  = !op[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
  assign last     = (cnt_q == SHW'(XLEN-1));

  always_comb begin
    base_res = '0;
    case (op)
      OpAdd:   base_res = src1 + src2;
      OpSll:   base_res = src1 << shamt;
      OpSlt:   base_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      OpSltu:  base_res = {{(XLEN-1){1'b0}}, src1 < src2};
      OpXor:   base_res = src1 ^ src2;
      OpSrl:   base_res = src1 >> shamt;
      OpOr:    base_res = src1 | src2;
      OpAnd:   base_res = src1 & src2;
      OpSub:   base_res = src1 - src2;
      OpSra:   base_res = $unsigned($signed(src1) >>> shamt);
      default: base_res = '0;
    endcase
  end

  // Shift-add step: multiplicand moves left, multiplier moves right.
  assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_prod = neg_q ? -mul_sum : mul_sum;

  // Restoring step: remainder in acc_q[XLEN:0], dividend/quotient in mcand_q[XLEN-1:0].
  assign rem_sh   = {acc_q[XLEN-1:0], mcand_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, mplier_q};
  assign q_bit    = !rem_diff[XLEN];
  assign rem_nx   = q_bit ? rem_diff : rem_sh;
  assign quo_nx   = {mcand_q[XLEN-2:0], q_bit};
  assign quo_fin  = neg_q ? -quo_nx : quo_nx;
  assign rem_fin  = rneg_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sel_d   = op[1:0];
          cnt_d   = '0;
          acc_d   = '0;
          mcand_d = {{XLEN{1'b0}}, mag1};
          mplier_d = mag2;
          neg_d   = neg1 ^ neg2;
          rneg_d  = neg1;
          if (is_mul) begin
            state_d = StMul;
          end else if (is_div) begin
            if (div_zero) begin
              state_d  = StDone;
              result_d = op[1] ? src1 : '1;
            end else if (div_ovf) begin
              state_d  = StDone;
              result_d = op[1] ? '0 : src1;
            end else begin
              state_d = StDiv;
            end
          end else begin
            state_d  = StDone;
            result_d = base_res;
          end
        end
      end
      StMul: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (last) begin
          state_d  = StDone;
          result_d = (sel_q == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
        end
      end
      StDiv: begin
        acc_d   = {{(XLEN-1){1'b0}}, rem_nx};
        mcand_d = {{XLEN{1'b0}}, quo_nx};
        cnt_d   = cnt_q + SHW'(1);
        if (last) begin
          state_d  = StDone;
          result_d = sel_q[1] ? rem_fin : quo_fin;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      sel_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at XLEN=32: results, latencies, handshakes,
// flush and asynchronous reset.
module tb_alu_muldiv;
  localparam int unsigned XLEN = 32;

  localparam logic [4:0] ADD = 5'd0,  SLT = 5'd2,  SLTU = 5'd3, SUB = 5'd8,  SRA = 5'd9;
  localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
  localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [4:0]      op;
  logic [XLEN-1:0] src1, src2, result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one op for one cycle, then scramble inputs to prove they were latched.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op = 5'd0; src1 = 32'hA5A5_5A5A; src2 = 32'h0F0F_0F0F;
  endtask

  task automatic wait_out(output int lat, output int busy_cyc);
    lat = 1;
    busy_cyc = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag, input logic [4:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat, bc;
    issue(o, a, b);
    wait_out(lat, bc);
    check({tag, " result"}, result, exp);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy cycles"}, bc, exp_lat - 1);
    @(negedge clk);
    check({tag, " release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, seen;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 5'd0; src1 = '0; src2 = '0;
    #12;
    check("reset outputs", {out_valid, busy, result}, 34'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset in_ready", {in_ready, out_valid, busy}, 3'b100);

    run("add wrap", ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
    run("sra shamt", SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 1);
    run("sub wrap", SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 1);
    run("slt", SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
    run("sltu", SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    run("undef op", 5'd12, 32'h1234, 32'h5678, 32'h0, 1);

    run("mulh", MULH, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33);
    run("mulhu", MULHU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 33);
    run("mul", MUL, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 33);
    run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33);

    run("div", DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33);
    run("rem", REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33);
    run("divu", DIVU, 32'd100, 32'd7, 32'd14, 33);
    run("remu", REMU, 32'd100, 32'd7, 32'd2, 33);

    run("div by 0", DIV, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
    run("rem by 0", REM, 32'h1234, 32'h0, 32'h1234, 1);
    run("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    issue(MUL, 32'd3, 32'd5);
    wait_out(lat, bc);
    check("bp latency", lat, 33);
    for (int i = 0; i < 10; i++) begin
      check("bp hold", {out_valid, in_ready, result}, {1'b1, 1'b0, 32'd15});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release", {out_valid, in_ready}, 2'b01);

    // Flush in the middle of a divide.
    issue(DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    check("flush pre busy", busy, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush idle", {out_valid, busy, in_ready}, 3'b001);
    seen = 0;
    repeat (40) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("flush no result", seen, 0);

    // Flush together with in_valid blocks the accept.
    in_valid = 1'b1; flush = 1'b1; op = ADD; src1 = 32'd1; src2 = 32'd1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush blocks accept", {out_valid, busy, in_ready}, 3'b001);
    @(negedge clk);
    check("flush blocks accept 2", out_valid, 1'b0);

    // Asynchronous reset partway through a multiply.
    issue(MUL, 32'd3, 32'd5);
    repeat (4) @(negedge clk);
    check("pre reset busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async reset", {out_valid, busy, in_ready, result}, {3'b001, 32'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset idle", {in_ready, out_valid, busy}, 3'b100);
    run("post reset add", ADD, 32'd2, 32'd3, 32'd5, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
